// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the two-requester cache memory port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
//
// Message layouts match the 4-byte memory messages the caches and test memory
// already exchange: request 77 bits, response 47 bits.
package cache_arb_pkg;

  // Requester id, also the owner FIFO entry type
  typedef logic arb_id_t;

  localparam int      ARB_NUM_REQ = 2;
  localparam arb_id_t ARB_REQ0    = 1'b0;
  localparam arb_id_t ARB_REQ1    = 1'b1;

  localparam logic [2:0] MEM_MSG_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_MSG_TYPE_WRITE = 3'd1;
  localparam logic [2:0] MEM_MSG_TYPE_INIT  = 3'd2;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  // Reads and writes are the message types that come in line-sized bursts
  function automatic logic is_line_burst_type(input logic [2:0] t);
    return (t == MEM_MSG_TYPE_READ) || (t == MEM_MSG_TYPE_WRITE);
  endfunction

endpackage

// File: rtl/cache_arb_owner_fifo.sv
// Owner FIFO: remembers which requester issued each in-flight memory request.
// Latency: push visible at head the cycle after; head is combinational from state.
// Backpressure: push ignored when full, pop ignored when empty (caller gates both).
//
// Ports: clk, reset (sync, active-high), push/push_id, pop, full, empty, head.
// DEPTH must be a power of two so the pointers wrap naturally.
module cache_arb_owner_fifo
  import cache_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  arb_id_t push_id,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output arb_id_t head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  arb_id_t         slots [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = slots[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      slots[wr_ptr] <= push_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cache_mem_port_arbiter.sv
// Shares one memory port between two cache requesters; round-robin per request.
// Latency: zero -- requests and responses pass combinationally in the same cycle.
// Backpressure: mem_req_rdy to the granted requester only; resp rdy of the owner to memory.
//
// Ports: clk, reset (sync, active-high);
//   req{0,1}_val/rdy/msg   requester request channels (mem_req_4B_t)
//   resp{0,1}_val/rdy/msg  requester response channels (mem_resp_4B_t)
//   mem_req_val/rdy/msg, mem_resp_val/rdy/msg  shared memory port
// Optional macro CACHE_ARB_LOCK_EN: keep a read/write burst of LINE_WORDS
// requests from one requester contiguous before switching.
module cache_mem_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int LINE_WORDS      = 4
) (
  input  logic         clk,
  input  logic         reset,

  input  logic         req0_val,
  output logic         req0_rdy,
  input  mem_req_4B_t  req0_msg,
  output logic         resp0_val,
  input  logic         resp0_rdy,
  output mem_resp_4B_t resp0_msg,

  input  logic         req1_val,
  output logic         req1_rdy,
  input  mem_req_4B_t  req1_msg,
  output logic         resp1_val,
  input  logic         resp1_rdy,
  output mem_resp_4B_t resp1_msg,

  output logic         mem_req_val,
  input  logic         mem_req_rdy,
  output mem_req_4B_t  mem_req_msg,
  input  logic         mem_resp_val,
  output logic         mem_resp_rdy,
  input  mem_resp_4B_t mem_resp_msg
);

  if (MAX_OUTSTANDING < 2 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0 ||
      LINE_WORDS < 1) begin : g_cfg_check
    $error("cache_mem_port_arbiter: MAX_OUTSTANDING must be a power of two >= 2, LINE_WORDS >= 1");
  end

  logic [ARB_NUM_REQ-1:0] req_val_vec;
  arb_id_t                prio;
  arb_id_t                rr_id;
  logic                   rr_vld;
  arb_id_t                sel_id;
  logic                   sel_vld;
  logic                   grant_vld;
  logic                   req_fire;
  logic                   resp_fire;
  logic                   route_vld;
  logic                   fifo_full;
  logic                   fifo_empty;
  arb_id_t                head_id;

  assign req_val_vec = {req1_val, req0_val};

  // Plain round-robin choice; prio only breaks ties
  assign rr_vld = |req_val_vec;
  assign rr_id  = (&req_val_vec) ? prio : (req1_val ? ARB_REQ1 : ARB_REQ0);

`ifdef CACHE_ARB_LOCK_EN
  localparam int BW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  logic          locked;
  arb_id_t       lock_id;
  logic [BW-1:0] burst_cnt;

  // While locked only the burst owner may be granted; the other side sees rdy 0
  assign sel_id  = locked ? lock_id : rr_id;
  assign sel_vld = locked ? req_val_vec[lock_id] : rr_vld;
`else
  assign sel_id  = rr_id;
  assign sel_vld = rr_vld;
`endif

  // Full gating uses the registered count: a same-cycle pop does not free a slot
  assign grant_vld   = sel_vld & ~fifo_full & ~reset;
  assign mem_req_val = grant_vld;
  assign mem_req_msg = (sel_id == ARB_REQ1) ? req1_msg : req0_msg;
  assign req0_rdy    = grant_vld & (sel_id == ARB_REQ0) & mem_req_rdy;
  assign req1_rdy    = grant_vld & (sel_id == ARB_REQ1) & mem_req_rdy;
  assign req_fire    = mem_req_val & mem_req_rdy;

  // Responses come back in order, so the FIFO head names their owner
  assign route_vld    = ~reset & ~fifo_empty;
  assign resp0_val    = route_vld & (head_id == ARB_REQ0) & mem_resp_val;
  assign resp1_val    = route_vld & (head_id == ARB_REQ1) & mem_resp_val;
  assign mem_resp_rdy = route_vld & ((head_id == ARB_REQ1) ? resp1_rdy : resp0_rdy);
  assign resp_fire    = mem_resp_val & mem_resp_rdy;
  assign resp0_msg    = mem_resp_msg;
  assign resp1_msg    = mem_resp_msg;

  cache_arb_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (req_fire),
    .push_id (sel_id),
    .pop     (resp_fire),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      prio      <= ARB_REQ0;
`ifdef CACHE_ARB_LOCK_EN
      locked    <= 1'b0;
      lock_id   <= ARB_REQ0;
      burst_cnt <= '0;
`endif
    end else begin
`ifdef CACHE_ARB_LOCK_EN
      if (locked) begin
        if (req_fire) begin
          if (burst_cnt == BW'(LINE_WORDS - 1)) begin
            locked    <= 1'b0;
            burst_cnt <= '0;
            prio      <= ~lock_id;
          end else begin
            burst_cnt <= burst_cnt + BW'(1);
          end
        end else if (!sel_vld) begin
          // Owner dropped val mid-burst: give the port back early
          locked    <= 1'b0;
          burst_cnt <= '0;
        end
      end else if (req_fire) begin
        if (is_line_burst_type(mem_req_msg.type_) && (LINE_WORDS > 1)) begin
          // First beat of a burst counts as beat one
          locked    <= 1'b1;
          lock_id   <= sel_id;
          burst_cnt <= BW'(1);
        end else begin
          prio <= ~sel_id;
        end
      end
`else
      if (req_fire) begin
        prio <= ~sel_id;
      end
`endif
    end
  end

endmodule
